// File: rtl/key_sampler_pkg.sv
// Shared types and parameter helpers for the key sampling front end.
package key_sampler_pkg;

   typedef enum logic [1:0] {
      RELEASED,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } db_state_t;

   function automatic int unsigned cycles_from_ms(input int unsigned clk_hz,
                                                  input int unsigned ms);
      return (clk_hz / 1000) * ms;
   endfunction

   // Bits needed to hold a counter running 0..n-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer on the inverted raw key plus a four-state debounce FSM.
module key_debounce
   import key_sampler_pkg::*;
#(
   parameter int unsigned DB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n_i,
   output logic db_level_o
);

   localparam int unsigned DB_W = cnt_width(DB_CYCLES);
   // Entering a wait state already accounts for the first stable cycle,
   // so the wait state exits once the counter reaches DB_CYCLES-2.
   localparam logic [DB_W-1:0] DB_LAST  = DB_W'((DB_CYCLES >= 2) ? DB_CYCLES - 2 : 0);
   localparam logic            DB_BYPASS = (DB_CYCLES == 1);

   logic      sync1_q;
   logic      key_s_q;
   db_state_t state_q, state_d;
   logic [DB_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         key_s_q <= 1'b0;
      end else begin
         sync1_q <= ~key_n_i;
         key_s_q <= sync1_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RELEASED;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         RELEASED: begin
            if (key_s_q) state_d = DB_BYPASS ? PRESSED : PRESS_WAIT;
         end
         PRESS_WAIT: begin
            if (!key_s_q)               state_d = RELEASED;
            else if (cnt_q == DB_LAST)  state_d = PRESSED;
            else                        cnt_d   = cnt_q + 1'b1;
         end
         PRESSED: begin
            if (!key_s_q) state_d = DB_BYPASS ? RELEASED : RELEASE_WAIT;
         end
         RELEASE_WAIT: begin
            if (key_s_q)                state_d = PRESSED;
            else if (cnt_q == DB_LAST)  state_d = RELEASED;
            else                        cnt_d   = cnt_q + 1'b1;
         end
         default: state_d = RELEASED;
      endcase
      if (state_d != state_q) cnt_d = '0;
   end

   assign db_level_o = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

endmodule

// File: rtl/key_bit_sampler.sv
// Debounced push-button sampled once per period into a serial bit with a valid strobe.
module key_bit_sampler
   import key_sampler_pkg::*;
#(
   parameter int unsigned CLK_HZ      = 50_000_000,
   parameter int unsigned DEBOUNCE_MS = 20,
   parameter int unsigned SAMPLE_HZ   = 1,
   parameter logic        LATCH       = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic bit_out,
   output logic bit_valid,
   output logic press_pulse,
   output logic tick_out
);

   localparam int unsigned DB_CYCLES = cycles_from_ms(CLK_HZ, DEBOUNCE_MS);
   localparam int unsigned P         = CLK_HZ / SAMPLE_HZ;
   localparam int unsigned CNT_W     = cnt_width(P);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(P / 2);

   logic             db_level;
   logic             db_prev_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sticky_q, sticky_d;
   logic             bit_q, bit_d;
   logic             valid_q, valid_d;
   logic             pulse_q, pulse_d;
   logic             tick_q, tick_d;
   logic             at_tick;

   key_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_debounce (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_n_i    (key_n),
      .db_level_o (db_level)
   );

   always_comb begin
      at_tick  = (cnt_q == CNT_LAST);
      cnt_d    = at_tick ? '0 : cnt_q + 1'b1;
      bit_d    = bit_q;
      sticky_d = sticky_q;
      valid_d  = at_tick;
      // A press seen on the tick edge itself belongs to the closing period.
      if (at_tick) begin
         bit_d    = LATCH ? (sticky_q | db_level) : db_level;
         sticky_d = 1'b0;
      end else if (db_level) begin
         sticky_d = 1'b1;
      end
      pulse_d = db_level & ~db_prev_q;
      tick_d  = (cnt_q >= CNT_HALF);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         sticky_q  <= 1'b0;
         bit_q     <= 1'b0;
         valid_q   <= 1'b0;
         pulse_q   <= 1'b0;
         tick_q    <= 1'b0;
         db_prev_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         sticky_q  <= sticky_d;
         bit_q     <= bit_d;
         valid_q   <= valid_d;
         pulse_q   <= pulse_d;
         tick_q    <= tick_d;
         db_prev_q <= db_level;
      end
   end

   assign bit_out     = bit_q;
   assign bit_valid   = valid_q;
   assign press_pulse = pulse_q;
   assign tick_out    = tick_q;

endmodule

// File: tb/tb_key_bit_sampler.sv
// Directed bench: DB_CYCLES=4, P=10, one LATCH=1 and one LATCH=0 instance on shared stimulus.
module tb_key_bit_sampler;

   logic clk = 1'b0;
   logic rst_n;
   logic key_n;
   logic bit1, valid1, pulse1, tick1;
   logic bit0, valid0, pulse0, tick0;

   int n_checks = 0;
   int n_errors = 0;
   int edge_n   = 0;
   int pulse_edge = 0;

   always #5 clk = ~clk;

   key_bit_sampler #(
      .CLK_HZ      (1000),
      .DEBOUNCE_MS (4),
      .SAMPLE_HZ   (100),
      .LATCH       (1'b1)
   ) u_dut_l1 (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_n       (key_n),
      .bit_out     (bit1),
      .bit_valid   (valid1),
      .press_pulse (pulse1),
      .tick_out    (tick1)
   );

   key_bit_sampler #(
      .CLK_HZ      (1000),
      .DEBOUNCE_MS (4),
      .SAMPLE_HZ   (100),
      .LATCH       (1'b0)
   ) u_dut_l0 (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_n       (key_n),
      .bit_out     (bit0),
      .bit_valid   (valid0),
      .press_pulse (pulse0),
      .tick_out    (tick0)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Edge k is the k-th rising edge after reset release; outputs sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      edge_n++;
      #1;
      chk($sformatf("valid1@%0d", edge_n), valid1, (edge_n % 10) == 0);
      chk($sformatf("valid0@%0d", edge_n), valid0, (edge_n % 10) == 0);
      chk($sformatf("tick1@%0d", edge_n), tick1, ((edge_n - 1) % 10) >= 5);
      chk($sformatf("tick0@%0d", edge_n), tick0, ((edge_n - 1) % 10) >= 5);
      chk($sformatf("pulse1@%0d", edge_n), pulse1, edge_n == pulse_edge);
      chk($sformatf("pulse0@%0d", edge_n), pulse0, edge_n == pulse_edge);
   endtask

   task automatic run_to(input int n);
      while (edge_n < n) step();
   endtask

   task automatic strobe(input int n, input logic exp1, input logic exp0);
      run_to(n);
      chk($sformatf("bit1@%0d", n), bit1, exp1);
      chk($sformatf("bit0@%0d", n), bit0, exp0);
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      #1;
      chk("rst_bit1", bit1, 0);     chk("rst_bit0", bit0, 0);
      chk("rst_valid1", valid1, 0); chk("rst_valid0", valid0, 0);
      chk("rst_pulse1", pulse1, 0); chk("rst_pulse0", pulse0, 0);
      chk("rst_tick1", tick1, 0);   chk("rst_tick0", tick0, 0);
      repeat (2) begin
         @(posedge clk);
         #1;
         chk("rst_hold_valid1", valid1, 0);
         chk("rst_hold_valid0", valid0, 0);
      end
      rst_n      = 1'b1;
      edge_n     = 0;
      pulse_edge = 0;
   endtask

   initial begin
      rst_n = 1'b1;
      key_n = 1'b1;
      #2;

      // Idle key: strobes at 10/20/30 carry 0
      reset_dut();
      strobe(10, 1'b0, 1'b0);
      strobe(20, 1'b0, 1'b0);
      strobe(30, 1'b0, 1'b0);

      // Three-cycle bounce is rejected
      reset_dut();
      run_to(2);  key_n = 1'b0;
      run_to(5);  key_n = 1'b1;
      strobe(10, 1'b0, 1'b0);
      strobe(20, 1'b0, 1'b0);

      // Six-cycle press from edge 12; release debounce keeps db_level up until edge 24
      reset_dut();
      pulse_edge = 19;
      run_to(12); key_n = 1'b0;
      run_to(18); key_n = 1'b1;
      strobe(20, 1'b1, 1'b1);
      strobe(30, 1'b1, 1'b0);
      strobe(40, 1'b0, 1'b0);

      // Minimal press debounced and released inside one period: only LATCH=1 reports it
      reset_dut();
      pulse_edge = 36;
      strobe(10, 1'b0, 1'b0);
      strobe(20, 1'b0, 1'b0);
      run_to(29); key_n = 1'b0;
      strobe(30, 1'b0, 1'b0);
      run_to(33); key_n = 1'b1;
      strobe(40, 1'b1, 1'b0);
      strobe(50, 1'b0, 1'b0);

      // db_level first high on the tick edge, key held
      reset_dut();
      pulse_edge = 20;
      strobe(10, 1'b0, 1'b0);
      run_to(13); key_n = 1'b0;
      strobe(20, 1'b1, 1'b1);
      strobe(30, 1'b1, 1'b1);
      key_n = 1'b1;

      // Reset mid-period with key held; counting restarts from release
      reset_dut();
      pulse_edge = 8;
      run_to(1); key_n = 1'b0;
      strobe(10, 1'b1, 1'b1);
      run_to(15);
      reset_dut();
      pulse_edge = 7;
      strobe(10, 1'b1, 1'b1);
      key_n = 1'b1;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
